// File: rtl/feed_skew_registers.sv
// feed_skew_registers: per-channel {valid,data} shift chains, channel c is BASE_DEPTH+c*STEP stages deep.
// Define FEED_SKEW_ZERO_GATE_EN to force o_dout of a channel to zero while its o_valid is low.
module feed_skew_registers #(
  parameter int N_CH       = 4,
  parameter int I_W        = 16,
  parameter int BASE_DEPTH = 1,
  parameter int STEP       = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_CH*I_W-1:0] i_din,
  input  logic              i_valid,
  input  logic              i_clear,
  input  logic              i_pipeline_en,
  output logic [N_CH*I_W-1:0] o_dout,
  output logic [N_CH-1:0]   o_valid,
  output logic              o_busy,
  output logic              o_flush_done
);
  logic [N_CH-1:0] ch_busy_d;
  logic busy_q, busy_d, flush_q, flush_d;
  if (BASE_DEPTH < 1 || N_CH < 1 || I_W < 1) begin : g_bad_cfg
    $fatal(1, "feed_skew_registers: BASE_DEPTH, N_CH and I_W must all be >= 1");
  end
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    localparam int D = BASE_DEPTH + c * STEP;
    logic [D-1:0]          vld_q, vld_d;
    logic [D-1:0][I_W-1:0] dat_q, dat_d;
    always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      if (i_pipeline_en) begin
        vld_d[0] = i_valid;
        dat_d[0] = i_din[c*I_W +: I_W];
        for (int s = 1; s < D; s++) begin
          vld_d[s] = vld_q[s-1];
          dat_d[s] = dat_q[s-1];
        end
      end
      if (i_clear) begin
        vld_d = '0;
        dat_d = '0;
      end
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        vld_q <= '0;
        dat_q <= '0;
      end else begin
        vld_q <= vld_d;
        dat_q <= dat_d;
      end
    end
    assign ch_busy_d[c] = |vld_d;
    assign o_valid[c]   = vld_q[D-1];
`ifdef FEED_SKEW_ZERO_GATE_EN
    assign o_dout[c*I_W +: I_W] = vld_q[D-1] ? dat_q[D-1] : '0;
`else
    assign o_dout[c*I_W +: I_W] = dat_q[D-1];
`endif
  end
  // Busy tracks the post-update valid stages; only a drain through an enabled shift counts as a flush.
  assign busy_d  = |ch_busy_d;
  assign flush_d = i_pipeline_en && !i_clear && busy_q && !busy_d;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy_q  <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      flush_q <= flush_d;
    end
  end
  assign o_busy       = busy_q;
  assign o_flush_done = flush_q;
endmodule
